mult_div_unit: RTL and testbench

- Iterative multiply/divide unit sitting directly downstream of the register file, consuming its two read operands (a = rs value, b = rt value).
- Executes MULT, MULTU, DIV and DIVU over WIDTH cycles and holds results in architectural HI/LO registers for later mfhi/mflo reads.
- Supports direct HI/LO writes (mthi/mtlo).
- Reports progress with a start/busy/done handshake so the control path can stall while an operation is in flight.

---
 rtl/mult_div_unit_if.sv | 30 +++
 rtl/mult_div_unit.sv | 146 ++++++++++++++
 tb/tb_mult_div_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Operand, command and result bundle between the register file / control path and the mult/div unit.
// Latency: none, wires only.
// Backpressure: the control path must hold off new starts while busy is high.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] write_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Control path side: issues operations and mthi/mtlo writes.
    modport master (
        output start, op, a, b, hi_we, lo_we, write_data,
        input  busy, done, hi, lo
    );

    // Unit side.
    modport slave (
        input  start, op, a, b, hi_we, lo_we, write_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into architectural HI/LO registers, plus mthi/mtlo writes.
// Latency: start at edge E0, result and done pulse at E(WIDTH+1).
// Backpressure: busy is high while in flight; start and HI/LO writes are ignored while busy.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             res_neg_q, res_neg_d;   // negate product / quotient
    logic             rem_neg_q, rem_neg_d;   // remainder takes dividend sign
    logic             dz_q, dz_d;             // divide by zero: skip sign fix
    logic [WIDTH-1:0] mcand_q, mcand_d;       // |multiplicand| or |divisor|
    logic [WIDTH-1:0] ph_q, ph_d;             // partial product high / remainder
    logic [WIDTH-1:0] pl_q, pl_d;             // multiplier bits / dividend->quotient
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             in_signed, a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum, trial, diff;
    logic [2*WIDTH-1:0] prod, prod_neg;

    // Next-state, datapath iteration and result fix-up.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        mcand_d   = mcand_q;
        ph_d      = ph_q;
        pl_d      = pl_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        // op[0]=0 selects the signed flavour for both MULT and DIV.
        in_signed = ~bus.op[0];
        a_neg     = in_signed & bus.a[WIDTH-1];
        b_neg     = in_signed & bus.b[WIDTH-1];
        abs_a     = a_neg ? -bus.a : bus.a;
        abs_b     = b_neg ? -bus.b : bus.b;

        mul_sum   = {1'b0, ph_q} + (pl_q[0] ? {1'b0, mcand_q} : '0);
        trial     = {ph_q, pl_q[WIDTH-1]};
        diff      = trial - {1'b0, mcand_q};
        prod      = {ph_q, pl_q};
        prod_neg  = -prod;

        unique case (state_q)
            IDLE: begin
                if (bus.hi_we) hi_d = bus.write_data;
                if (bus.lo_we) lo_d = bus.write_data;
                if (bus.start) begin
                    op_d      = bus.op;
                    res_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    dz_d      = bus.op[1] && (bus.b == '0);
                    // Raw dividend on divide-by-zero so the remainder comes out as a itself.
                    pl_d      = (bus.op[1] && (bus.b == '0)) ? bus.a : abs_a;
                    ph_d      = '0;
                    mcand_d   = abs_b;
                    cnt_d     = CW'(WIDTH - 1);
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (op_q[1]) begin
                    // Restoring division: keep the subtraction only if it did not borrow.
                    if (!diff[WIDTH]) begin
                        ph_d = diff[WIDTH-1:0];
                        pl_d = {pl_q[WIDTH-2:0], 1'b1};
                    end else begin
                        ph_d = trial[WIDTH-1:0];
                        pl_d = {pl_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    {ph_d, pl_d} = {mul_sum, pl_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FIX: begin
                if (!op_q[1]) begin
                    {hi_d, lo_d} = (~op_q[0] && res_neg_q) ? prod_neg : prod;
                end else if (dz_q || op_q[0]) begin
                    hi_d = ph_q;
                    lo_d = pl_q;
                end else begin
                    hi_d = rem_neg_q ? -ph_q : ph_q;
                    lo_d = res_neg_q ? -pl_q : pl_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            mcand_q   <= '0;
            ph_q      <= '0;
            pl_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            mcand_q   <= mcand_d;
            ph_q      <= ph_d;
            pl_q      <= pl_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed results.
// Latency: checks the WIDTH+1 cycle start-to-done timing.
// Backpressure: checks that starts and HI/LO writes during busy are dropped.
module tb_mult_div_unit;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for done. With interfere set, an
    // mthi write, a second start and operand changes are thrown in mid-flight.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit interfere);
        int k;
        logic [31:0] hi_before;
        hi_before = bus.hi;
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        step();                      // edge E0
        bus.start = 1'b0;
        check({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
        k = 0;
        while (k < 40) begin
            if (interfere) begin
                if (k == 3)  begin bus.a = 32'd55; bus.b = 32'd9; bus.op = 2'b00; end
                if (k == 5)  begin bus.hi_we = 1'b1; bus.write_data = 32'hDEADBEEF; end
                if (k == 6)  begin
                    bus.hi_we = 1'b0;
                    check({tag, "_hi_held"}, bus.hi, hi_before);
                end
                if (k == 10) begin bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd1000; bus.b = 32'd3; end
                if (k == 11) bus.start = 1'b0;
            end
            step();
            k++;
            if (bus.done) break;
            if (!bus.busy) break;
        end
        check({tag, "_latency"}, 32'(k), 32'd33);
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
        step();
        check({tag, "_done_fall"}, 32'(bus.done), 32'd0);
        check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.write_data = '0;
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_hi",   bus.hi, 32'd0);
        check("rst_lo",   bus.lo, 32'd0);
        rst_n = 1'b1;
        step();

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("divu_zero", 2'b11, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b0);
        run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("divu_intf", 2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b1);

        // Reset in the middle of MULTU 6*7.
        bus.op = 2'b01; bus.a = 32'd6; bus.b = 32'd7; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (14) step();
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_hi",   bus.hi, 32'd0);
        check("mid_rst_lo",   bus.lo, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_hi", bus.hi, 32'd0);
        run_op("multu_6x7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        // mthi / mtlo in IDLE.
        bus.hi_we = 1'b1; bus.write_data = 32'h12345678;
        step();
        bus.hi_we = 1'b0;
        check("mthi_hi",   bus.hi, 32'h12345678);
        check("mthi_lo",   bus.lo, 32'd42);
        check("mthi_done", 32'(bus.done), 32'd0);
        step();
        bus.lo_we = 1'b1; bus.write_data = 32'h9ABCDEF0;
        step();
        bus.lo_we = 1'b0;
        check("mtlo_lo",   bus.lo, 32'h9ABCDEF0);
        check("mtlo_hi",   bus.hi, 32'h12345678);
        check("mtlo_done", 32'(bus.done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
